// File: rtl/masku_result_shuffle.sv
// +----------------------------------------------------------------------------+
// | masku_result_shuffle                                                       |
// | Reshuffles sequential mask-unit results into per-lane VRF layout and       |
// | writes them to the lanes through a small result FIFO.                      |
// | Optional: define MASKU_SHUFFLE_ZERO_SKIP_EN to skip lanes with no bytes.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module masku_result_shuffle #(
  parameter int unsigned NrLanes   = 4,
  parameter int unsigned ELEN      = 64,
  parameter int unsigned Depth     = 2,
  parameter int unsigned AddrWidth = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [1:0]                    req_eew_i,
  input  logic [AddrWidth-1:0]          req_addr_i,
  input  logic [15:0]                   req_nr_words_i,
  input  logic                          res_valid_i,
  output logic                          res_ready_o,
  input  logic [NrLanes*ELEN-1:0]       res_data_i,
  input  logic [NrLanes*(ELEN/8)-1:0]   res_be_i,
  output logic [NrLanes-1:0]            lane_wvalid_o,
  input  logic [NrLanes-1:0]            lane_wready_i,
  output logic [NrLanes*ELEN-1:0]       lane_wdata_o,
  output logic [NrLanes*(ELEN/8)-1:0]   lane_wbe_o,
  output logic [AddrWidth-1:0]          lane_waddr_o,
  output logic                          done_o
);

  localparam int unsigned c_elenb  = ELEN / 8;
  localparam int unsigned c_data_w = NrLanes * ELEN;
  localparam int unsigned c_be_w   = NrLanes * c_elenb;
  localparam int unsigned c_ptr_w  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned c_cnt_w  = $clog2(Depth + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e                r_state, w_state_next;
  logic [1:0]            r_eew;
  logic [AddrWidth-1:0]  r_addr;
  logic [15:0]           r_nr_words;
  logic [15:0]           r_acc_cnt;
  logic [15:0]           r_pop_cnt;

  logic [c_data_w-1:0]   r_fifo_data [Depth];
  logic [c_be_w-1:0]     r_fifo_be   [Depth];
  logic [c_ptr_w-1:0]    r_wr_ptr, r_rd_ptr;
  logic [c_cnt_w-1:0]    r_count;
  logic [NrLanes-1:0]    r_sent;

  logic [c_data_w-1:0]   w_shuf_data;
  logic [c_be_w-1:0]     w_shuf_be;
  logic [c_data_w-1:0]   w_head_data;
  logic [c_be_w-1:0]     w_head_be;
  logic                  w_head_valid;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic [NrLanes-1:0]    w_lane_en;
  logic [NrLanes-1:0]    w_lane_done;

  // Destination byte of sequential byte b for element width 1<<eew.
  function automatic int unsigned dest_byte(input int unsigned b, input logic [1:0] eew);
    int unsigned sz;
    int unsigned e;
    sz = 32'd1 << eew;
    e  = b >> eew;
    return (e % NrLanes) * c_elenb + (e / NrLanes) * sz + (b % sz);
  endfunction

  always_comb begin
    int unsigned dst;
    dst         = 0;
    w_shuf_data = '0;
    w_shuf_be   = '0;
    for (int unsigned b = 0; b < c_be_w; b++) begin
      dst = dest_byte(b, r_eew);
      w_shuf_data[dst*8 +: 8] = res_data_i[b*8 +: 8];
      w_shuf_be[dst]          = res_be_i[b];
    end
  end

  assign w_full       = (r_count == c_cnt_w'(Depth));
  assign w_head_valid = (r_count != '0);
  assign w_head_data  = r_fifo_data[r_rd_ptr];
  assign w_head_be    = r_fifo_be[r_rd_ptr];

  // Full means no accept, even when the head pops this cycle: keeps lane_wready_i off res_ready_o.
  assign res_ready_o  = (r_state == ST_ACTIVE) && !w_full && (r_acc_cnt < r_nr_words);
  assign w_push       = res_valid_i && res_ready_o;
  assign w_pop        = w_head_valid && (&w_lane_done);

  for (genvar l = 0; l < NrLanes; l++) begin : g_lane
`ifdef MASKU_SHUFFLE_ZERO_SKIP_EN
    assign w_lane_en[l] = |w_head_be[l*c_elenb +: c_elenb];
`else
    assign w_lane_en[l] = 1'b1;
`endif
    assign lane_wvalid_o[l] = w_head_valid && !r_sent[l] && w_lane_en[l];
    assign w_lane_done[l]   = r_sent[l] || !w_lane_en[l] || lane_wready_i[l];
  end

  assign lane_wdata_o = w_head_valid ? w_head_data : '0;
  assign lane_wbe_o   = w_head_valid ? w_head_be   : '0;
  assign lane_waddr_o = r_addr + AddrWidth'(r_pop_cnt);

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= w_shuf_data;
      r_fifo_be[r_wr_ptr]   <= w_shuf_be;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_sent   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_ptr_w'(Depth - 1)) ? '0 : r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_ptr_w'(Depth - 1)) ? '0 : r_rd_ptr + c_ptr_w'(1);
        r_sent   <= '0;
      end else begin
        r_sent   <= r_sent | (lane_wvalid_o & lane_wready_i);
      end
      r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_eew      <= '0;
      r_addr     <= '0;
      r_nr_words <= '0;
      r_acc_cnt  <= '0;
      r_pop_cnt  <= '0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == ST_IDLE) && req_valid_i) begin
        r_eew      <= req_eew_i;
        r_addr     <= req_addr_i;
        r_nr_words <= req_nr_words_i;
        r_acc_cnt  <= '0;
        r_pop_cnt  <= '0;
      end else begin
        if (w_push) r_acc_cnt <= r_acc_cnt + 16'd1;
        if (w_pop)  r_pop_cnt <= r_pop_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    req_ready_o  = 1'b0;
    done_o       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          w_state_next = (req_nr_words_i == 16'd0) ? ST_DONE : ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (w_pop && (r_pop_cnt == r_nr_words - 16'd1)) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done_o       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_masku_result_shuffle.sv
// +----------------------------------------------------------------------------+
// | tb_masku_result_shuffle                                                    |
// | Directed self-checking bench for masku_result_shuffle (4 lanes, 64b).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_masku_result_shuffle;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_eew;
  logic [15:0]   req_addr;
  logic [15:0]   req_nr_words;
  logic          res_valid;
  logic          res_ready;
  logic [255:0]  res_data;
  logic [31:0]   res_be;
  logic [3:0]    lane_wvalid;
  logic [3:0]    lane_wready;
  logic [255:0]  lane_wdata;
  logic [31:0]   lane_wbe;
  logic [15:0]   lane_waddr;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_full = 1'b0;

  // Monitor log, cleared on every request handshake and on reset
  logic [63:0] hs_data [4][8];
  logic [15:0] hs_addr [4][8];
  logic [7:0]  hs_be   [4][8];
  int          hs_cnt  [4];
  int          vld_cnt [4];
  bit          hold    [4];
  logic [63:0] hold_data [4];
  logic [15:0] hold_addr [4];
  logic [7:0]  hold_be   [4];
  int hs_last, req_cyc, done_cyc, done_cnt, acc_cnt, stable_err, full_viol;
  bit full_seen;

  masku_result_shuffle #(
    .NrLanes(4), .ELEN(64), .Depth(2), .AddrWidth(16)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_eew_i(req_eew), .req_addr_i(req_addr), .req_nr_words_i(req_nr_words),
    .res_valid_i(res_valid), .res_ready_o(res_ready),
    .res_data_i(res_data), .res_be_i(res_be),
    .lane_wvalid_o(lane_wvalid), .lane_wready_i(lane_wready),
    .lane_wdata_o(lane_wdata), .lane_wbe_o(lane_wbe),
    .lane_waddr_o(lane_waddr), .done_o(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int mn;
    int occ;
    if (rst || (req_valid && req_ready)) begin
      for (int l = 0; l < 4; l++) begin
        hs_cnt[l] = 0; vld_cnt[l] = 0; hold[l] = 1'b0;
      end
      acc_cnt = 0; done_cnt = 0; full_seen = 1'b0; full_viol = 0; stable_err = 0;
      if (!rst) req_cyc = cyc;
    end
    mn = hs_cnt[0];
    for (int l = 1; l < 4; l++) if (hs_cnt[l] < mn) mn = hs_cnt[l];
    occ = acc_cnt - mn;
    if (chk_full && occ >= 2) begin
      full_seen = 1'b1;
      if (res_ready) full_viol++;
    end
    for (int l = 0; l < 4; l++) begin
      if (hold[l] && (!lane_wvalid[l] || lane_wdata[l*64 +: 64] !== hold_data[l] ||
                      lane_waddr !== hold_addr[l] || lane_wbe[l*8 +: 8] !== hold_be[l]))
        stable_err++;
      hold[l]      = lane_wvalid[l] && !lane_wready[l];
      hold_data[l] = lane_wdata[l*64 +: 64];
      hold_addr[l] = lane_waddr;
      hold_be[l]   = lane_wbe[l*8 +: 8];
      if (lane_wvalid[l]) vld_cnt[l]++;
      if (lane_wvalid[l] && lane_wready[l]) begin
        if (hs_cnt[l] < 8) begin
          hs_data[l][hs_cnt[l]] = lane_wdata[l*64 +: 64];
          hs_addr[l][hs_cnt[l]] = lane_waddr;
          hs_be[l][hs_cnt[l]]   = lane_wbe[l*8 +: 8];
        end
        hs_cnt[l]++;
        hs_last = cyc;
      end
    end
    if (res_valid && res_ready) acc_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
  end

  function automatic logic [255:0] mk(input logic [7:0] base);
    logic [255:0] d;
    for (int i = 0; i < 32; i++) d[i*8 +: 8] = base + 8'(i);
    return d;
  endfunction

  // Stimulus helpers: entered and left at #1 after a rising edge
  task automatic do_req(input logic [1:0] eew, input logic [15:0] addr, input logic [15:0] nw);
    req_valid = 1'b1; req_eew = eew; req_addr = addr; req_nr_words = nw;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic send_words(input int n, input logic [7:0] base, input logic [31:0] be);
    bit got;
    for (int w = 0; w < n; w++) begin
      res_valid = 1'b1; res_data = mk(8'(base + 8'(32 * w))); res_be = be;
      got = 1'b0;
      for (int t = 0; t < 50 && !got; t++) begin
        @(negedge clk); got = res_ready;
        @(posedge clk); #1;
      end
      n_tests++;
      if (!got) begin n_fail++; $display("FAIL send_timeout word=%0d got=not_accepted exp=accepted", w); end
    end
    res_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk); seen = done;
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL %s_done_timeout got=0 exp=1", name); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({req_ready, res_ready, lane_wvalid, done} !== 7'b1000000) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=1000000", {req_ready, res_ready, lane_wvalid, done});
    end
    n_tests++;
    if (lane_waddr !== 16'h0 || lane_wdata !== '0 || lane_wbe !== '0) begin
      n_fail++; $display("FAIL reset_data got addr=%h be=%h exp 0", lane_waddr, lane_wbe);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_eew3;
    logic [63:0] exp_d [4] = '{64'h0706050403020100, 64'h0f0e0d0c0b0a0908,
                               64'h1716151413121110, 64'h1f1e1d1c1b1a1918};
    lane_wready = 4'hF;
    do_req(2'd3, 16'h0010, 16'd1);
    send_words(1, 8'h00, 32'hFFFF_FFFF);
    wait_done("eew3");
    for (int l = 0; l < 4; l++) begin
      n_tests++;
      if (hs_cnt[l] !== 1 || hs_data[l][0] !== exp_d[l] || hs_addr[l][0] !== 16'h0010 || hs_be[l][0] !== 8'hFF) begin
        n_fail++;
        $display("FAIL eew3_lane%0d got n=%0d d=%h a=%h be=%h exp n=1 d=%h a=0010 be=ff",
                 l, hs_cnt[l], hs_data[l][0], hs_addr[l][0], hs_be[l][0], exp_d[l]);
      end
    end
    n_tests++;
    if (done_cyc !== hs_last + 1 || done_cnt !== 1) begin
      n_fail++; $display("FAIL eew3_done_timing got=%0d cnt=%0d exp=%0d cnt=1", done_cyc, done_cnt, hs_last + 1);
    end
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL eew3_req_ready_after got=%b exp=1", req_ready); end
  endtask

  task automatic test_eew0;
    logic [63:0] exp_d [4] = '{64'h1c1814100c080400, 64'h1d1915110d090501,
                               64'h1e1a16120e0a0602, 64'h1f1b17130f0b0703};
    lane_wready = 4'hF;
    do_req(2'd0, 16'h0020, 16'd1);
    send_words(1, 8'h00, 32'hFFFF_FFFF);
    wait_done("eew0");
    for (int l = 0; l < 4; l++) begin
      n_tests++;
      if (hs_cnt[l] !== 1 || hs_data[l][0] !== exp_d[l] || hs_be[l][0] !== 8'hFF) begin
        n_fail++;
        $display("FAIL eew0_lane%0d got n=%0d d=%h be=%h exp n=1 d=%h be=ff",
                 l, hs_cnt[l], hs_data[l][0], hs_be[l][0], exp_d[l]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp_l0 [3] = '{64'h1918111009080100, 64'h3938313029282120, 64'h5958515049484140};
    logic [63:0] exp_l2 [3] = '{64'h1d1c15140d0c0504, 64'h3d3c35342d2c2524, 64'h5d5c55544d4c4544};
    chk_full = 1'b1;
    fork
      begin
        do_req(2'd1, 16'h0010, 16'd3);
        send_words(3, 8'h00, 32'hFFFF_FFFF);
      end
      begin
        lane_wready = 4'b1011;
        for (int t = 0; t < 50 && lane_wvalid == 4'b0; t++) @(negedge clk);
        repeat (5) @(posedge clk);
        #1 lane_wready = 4'b0111;
        repeat (2) @(posedge clk);
        #1 lane_wready = 4'b1111;
      end
    join
    wait_done("b2b");
    chk_full = 1'b0;
    for (int l = 0; l < 4; l++) begin
      n_tests++;
      if (hs_cnt[l] !== 3 || hs_addr[l][0] !== 16'h0010 || hs_addr[l][1] !== 16'h0011 || hs_addr[l][2] !== 16'h0012) begin
        n_fail++;
        $display("FAIL b2b_addr_lane%0d got n=%0d a=%h,%h,%h exp n=3 a=0010,0011,0012",
                 l, hs_cnt[l], hs_addr[l][0], hs_addr[l][1], hs_addr[l][2]);
      end
    end
    for (int w = 0; w < 3; w++) begin
      n_tests++;
      if (hs_data[0][w] !== exp_l0[w] || hs_data[2][w] !== exp_l2[w]) begin
        n_fail++;
        $display("FAIL b2b_data_w%0d got l0=%h l2=%h exp l0=%h l2=%h",
                 w, hs_data[0][w], hs_data[2][w], exp_l0[w], exp_l2[w]);
      end
    end
    n_tests++;
    if (full_seen !== 1'b1 || full_viol !== 0) begin
      n_fail++; $display("FAIL b2b_full_backpressure got seen=%0d viol=%0d exp seen=1 viol=0", full_seen, full_viol);
    end
    n_tests++;
    if (stable_err !== 0) begin n_fail++; $display("FAIL b2b_valid_stable got=%0d exp=0", stable_err); end
  endtask

  task automatic test_zero_skip;
    lane_wready = 4'hF;
    do_req(2'd3, 16'h0020, 16'd1);
    send_words(1, 8'h00, 32'h0000_00FF);
    wait_done("zskip");
    n_tests++;
    if (hs_data[0][0] !== 64'h0706050403020100 || hs_be[0][0] !== 8'hFF) begin
      n_fail++; $display("FAIL zskip_lane0 got d=%h be=%h exp d=0706050403020100 be=ff", hs_data[0][0], hs_be[0][0]);
    end
`ifdef MASKU_SHUFFLE_ZERO_SKIP_EN
    n_tests++;
    if (hs_cnt[0] !== 1 || vld_cnt[1] !== 0 || vld_cnt[2] !== 0 || vld_cnt[3] !== 0) begin
      n_fail++; $display("FAIL zskip_valids got n0=%0d v=%0d,%0d,%0d exp n0=1 v=0,0,0",
                         hs_cnt[0], vld_cnt[1], vld_cnt[2], vld_cnt[3]);
    end
`else
    for (int l = 1; l < 4; l++) begin
      n_tests++;
      if (hs_cnt[l] !== 1 || hs_be[l][0] !== 8'h00) begin
        n_fail++; $display("FAIL zskip_lane%0d got n=%0d be=%h exp n=1 be=00", l, hs_cnt[l], hs_be[l][0]);
      end
    end
`endif
  endtask

  task automatic test_zero_words;
    lane_wready = 4'hF;
    do_req(2'd2, 16'h0030, 16'd0);
    wait_done("zero");
    n_tests++;
    if (done_cyc !== req_cyc + 1) begin
      n_fail++; $display("FAIL zero_done_timing got=%0d exp=%0d", done_cyc, req_cyc + 1);
    end
    n_tests++;
    if (vld_cnt[0] + vld_cnt[1] + vld_cnt[2] + vld_cnt[3] !== 0) begin
      n_fail++; $display("FAIL zero_no_valid got=%0d exp=0", vld_cnt[0] + vld_cnt[1] + vld_cnt[2] + vld_cnt[3]);
    end
  endtask

  task automatic test_addr_wrap;
    lane_wready = 4'hF;
    do_req(2'd3, 16'hFFFF, 16'd2);
    send_words(2, 8'h00, 32'hFFFF_FFFF);
    wait_done("wrap");
    n_tests++;
    if (hs_addr[0][0] !== 16'hFFFF || hs_addr[0][1] !== 16'h0000 || hs_data[3][1] !== 64'h3f3e3d3c3b3a3938) begin
      n_fail++; $display("FAIL wrap got a=%h,%h d3=%h exp a=ffff,0000 d3=3f3e3d3c3b3a3938",
                         hs_addr[0][0], hs_addr[0][1], hs_data[3][1]);
    end
  endtask

  task automatic test_reset_mid;
    lane_wready = 4'b1101;
    do_req(2'd3, 16'h0040, 16'd2);
    send_words(2, 8'h00, 32'hFFFF_FFFF);
    @(negedge clk);
    n_tests++;
    if (lane_wvalid !== 4'b0010 || res_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_pending got v=%b rr=%b exp v=0010 rr=0", lane_wvalid, res_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({req_ready, res_ready, lane_wvalid, done} !== 7'b1000000 || lane_waddr !== 16'h0 ||
        lane_wdata !== '0 || lane_wbe !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs got ctrl=%b a=%h be=%h exp ctrl=1000000 a=0000 be=0",
                         {req_ready, res_ready, lane_wvalid, done}, lane_waddr, lane_wbe);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    lane_wready = 4'hF;
    do_req(2'd3, 16'h0050, 16'd1);
    send_words(1, 8'h80, 32'hFFFF_FFFF);
    wait_done("rstmid");
    n_tests++;
    if (hs_cnt[1] !== 1 || hs_data[1][0] !== 64'h8f8e8d8c8b8a8988 || hs_addr[1][0] !== 16'h0050) begin
      n_fail++; $display("FAIL rstmid_fresh got n=%0d d=%h a=%h exp n=1 d=8f8e8d8c8b8a8988 a=0050",
                         hs_cnt[1], hs_data[1][0], hs_addr[1][0]);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_eew = '0; req_addr = '0; req_nr_words = '0;
    res_valid = 1'b0; res_data = '0; res_be = '0; lane_wready = 4'hF;
    #1;
    test_reset;
    test_eew3;
    test_eew0;
    test_back_to_back;
    test_zero_skip;
    test_zero_words;
    test_addr_wrap;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
